// File: rtl/ofe_tx_serializer.sv
// rtl/ofe_tx_serializer.sv - parallel-to-serial gearbox feeding an enable/preset output flop
module ofe_tx_serializer #(
  parameter int   WIDTH     = 4,
  parameter logic IDLE_VAL  = 1'b1,
  parameter bit   LSB_FIRST = 1'b1
) (
  input  logic             ECLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             D_OUT,
  output logic             SP_OUT,
  output logic             BUSY
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              hf_q, hf_d;
  logic [WIDTH-1:0]  hr_q, hr_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              sp_q, sp_d;

  logic              ld;
  logic              accept;

  // A held word moves into the shifter when the shifter is free or on its last bit,
  // which is what makes back-to-back words gapless.
  assign ld     = hf_q & ((state_q != SHIFT) | (cnt_q == CNT_LAST));
  assign DREADY = ~RST & (~hf_q | ld);
  assign accept = DVALID & DREADY;

  assign D_OUT  = dout_q;
  assign SP_OUT = sp_q;
  assign BUSY   = hf_q | (state_q != IDLE);

  // Next-state logic: load / shift / tail sequencing plus the hold-register handshake.
  always_comb begin
    state_d = state_q;
    hf_d    = hf_q;
    hr_d    = hr_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sp_d    = sp_q;

    if (ld) begin
      sr_d    = hr_q;
      dout_d  = LSB_FIRST ? hr_q[0] : hr_q[WIDTH-1];
      sp_d    = 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
      hf_d    = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          sp_d = 1'b1;
          if (cnt_q != CNT_LAST) begin
            // The bit on D_OUT is always the edge bit of SR; present its neighbour next.
            dout_d = LSB_FIRST ? sr_q[1] : sr_q[WIDTH-2];
            sr_d   = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
            cnt_d  = cnt_q + 1'b1;
          end else begin
            // One extra enabled cycle so the output flop captures the idle level.
            dout_d  = IDLE_VAL;
            cnt_d   = '0;
            state_d = TAIL;
          end
        end
        TAIL: begin
          dout_d  = IDLE_VAL;
          sp_d    = 1'b0;
          state_d = IDLE;
        end
        default: begin
          sp_d = 1'b0;
        end
      endcase
    end

    // Accept after the load so a same-edge accept refills HR and keeps HF set.
    if (accept) begin
      hr_d = DIN;
      hf_d = 1'b1;
    end
  end

  // State register with synchronous reset; outputs come straight from these flops.
  always_ff @(posedge ECLK) begin
    if (RST) begin
      state_q <= IDLE;
      hf_q    <= 1'b0;
      hr_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= IDLE_VAL;
      sp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hf_q    <= hf_d;
      hr_q    <= hr_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sp_q    <= sp_d;
    end
  end

endmodule

// File: tb/tb_ofe_tx_serializer.sv
// tb/tb_ofe_tx_serializer.sv - directed self-checking bench for ofe_tx_serializer
module tb_ofe_tx_serializer;

  logic       ECLK = 1'b0;
  logic       RST;
  logic [3:0] din_a;
  logic       dvalid_a;
  logic       dready_a, dout_a, sp_a, busy_a;
  logic [7:0] din_b;
  logic       dvalid_b;
  logic       dready_b, dout_b, sp_b, busy_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ofe_tx_serializer #(.WIDTH(4), .IDLE_VAL(1'b1), .LSB_FIRST(1'b1)) u_a (
    .ECLK(ECLK), .RST(RST), .DIN(din_a), .DVALID(dvalid_a), .DREADY(dready_a),
    .D_OUT(dout_a), .SP_OUT(sp_a), .BUSY(busy_a)
  );

  ofe_tx_serializer #(.WIDTH(8), .IDLE_VAL(1'b1), .LSB_FIRST(1'b0)) u_b (
    .ECLK(ECLK), .RST(RST), .DIN(din_b), .DVALID(dvalid_b), .DREADY(dready_b),
    .D_OUT(dout_b), .SP_OUT(sp_b), .BUSY(busy_b)
  );

  always #5 ECLK = ~ECLK;

  task automatic tick();
    @(posedge ECLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  b2b_bits;
    logic [11:0] stall_bits;
    logic [7:0]  msb_bits;
    logic [3:0]  words [3];
    int          idx;
    logic        rdy, vld;

    b2b_bits   = 8'b0011_1010;        // emitted order is bit 0 first: 0,1,0,1,1,1,0,0
    stall_bits = 12'b0101_0000_1111;  // F, 0, 5 each LSB first
    msb_bits   = 8'h96;
    words[0] = 4'hF; words[1] = 4'h0; words[2] = 4'h5;

    // Reset held 3 cycles with DVALID high
    RST = 1'b1; dvalid_a = 1'b1; din_a = 4'hA; dvalid_b = 1'b0; din_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_dout",   dout_a,   1'b1);
      chk("rst_sp",     sp_a,     1'b0);
      chk("rst_dready", dready_a, 1'b0);
      chk("rst_busy",   busy_a,   1'b0);
    end
    RST = 1'b0;
    #1;
    chk("post_rst_dready", dready_a, 1'b1);

    // Single word 4'b1010: accept at edge 0, bits on edges 1-4, tail on 5, idle on 6
    tick();
    dvalid_a = 1'b0;
    chk("single_busy_after_accept", busy_a, 1'b1);
    chk("single_sp_after_accept",   sp_a,   1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("single_bit", dout_a, (k == 1 || k == 3) ? 1'b1 : 1'b0);
      chk("single_sp",  sp_a,   1'b1);
    end
    tick();
    chk("single_tail_dout", dout_a, 1'b1);
    chk("single_tail_sp",   sp_a,   1'b1);
    tick();
    chk("single_idle_sp",   sp_a,   1'b0);
    chk("single_idle_busy", busy_a, 1'b0);
    chk("single_idle_dout", dout_a, 1'b1);

    // Back-to-back A then 3 with no gap
    dvalid_a = 1'b1; din_a = 4'hA;
    tick();
    chk("b2b_dready_edge0", dready_a, 1'b1);
    din_a = 4'h3;
    tick();
    dvalid_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("b2b_bit",    dout_a,   b2b_bits[k]);
      chk("b2b_sp",     sp_a,     1'b1);
      chk("b2b_dready", dready_a, (k >= 3) ? 1'b1 : 1'b0);
    end
    tick();
    chk("b2b_tail_dout", dout_a, 1'b1);
    chk("b2b_tail_sp",   sp_a,   1'b1);
    tick();
    chk("b2b_idle_sp", sp_a, 1'b0);

    // Stall: F, 0, 5 offered continuously; stream must be their concatenation
    idx = 0;
    for (int i = 0; i <= 12; i++) begin
      vld = (idx < 3);
      dvalid_a = vld;
      din_a = vld ? words[idx] : 4'h0;
      #1;
      rdy = dready_a;
      tick();
      if (rdy && vld) idx++;
      if (i >= 1) begin
        chk("stall_bit", dout_a, stall_bits[i-1]);
        chk("stall_sp",  sp_a,   1'b1);
      end
    end
    dvalid_a = 1'b0;
    chk("stall_accepted", idx, 3);
    tick();
    chk("stall_tail_dout", dout_a, 1'b1);
    tick();
    chk("stall_idle_sp", sp_a, 1'b0);
    chk("stall_idle_busy", busy_a, 1'b0);

    // Reset after the 2nd bit of 4'b1100
    dvalid_a = 1'b1; din_a = 4'b1100;
    tick();
    dvalid_a = 1'b0;
    tick();
    chk("mid_bit0", dout_a, 1'b0);
    tick();
    chk("mid_bit1", dout_a, 1'b0);
    RST = 1'b1;
    tick();
    chk("mid_rst_dout", dout_a, 1'b1);
    chk("mid_rst_sp",   sp_a,   1'b0);
    chk("mid_rst_busy", busy_a, 1'b0);
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_after_dout", dout_a, 1'b1);
      chk("mid_after_sp",   sp_a,   1'b0);
    end

    // MSB-first, WIDTH=8, 8'h96
    dvalid_b = 1'b1; din_b = 8'h96;
    #1;
    chk("msb_dready", dready_b, 1'b1);
    tick();
    dvalid_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("msb_bit", dout_b, msb_bits[7-k]);
      chk("msb_sp",  sp_b,   1'b1);
    end
    tick();
    chk("msb_tail_dout", dout_b, 1'b1);
    chk("msb_tail_sp",   sp_b,   1'b1);
    tick();
    chk("msb_idle_sp",   sp_b,   1'b0);
    chk("msb_idle_busy", busy_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
